// File: rtl/bubblesort_pkg.sv
// Shared types and helpers for the bubble-sort array sequencer.
package bubblesort_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StSort,
    StUnload
  } sortState_e;

  // Beat counter must hold the larger of the key count and the pass count.
  function automatic int unsigned cntWidth(int unsigned depth, int unsigned passes);
    int unsigned maxBeats;
    maxBeats = (depth > passes) ? depth : passes;
    return $clog2(maxBeats + 1);
  endfunction

endpackage

// File: rtl/bubblesort_beat_counter.sv
// Beat counter with synchronous clear, increment and a terminal-value compare.
module bubblesort_beat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             clear,
  input  logic             incr,
  input  logic [CNT_W-1:0] terminal,
  output logic             atTerminal
);

  logic [CNT_W-1:0] countQ, countD;

  always_comb begin
    countD = countQ;
    if (clear) begin
      countD = '0;
    end else if (incr) begin
      countD = countQ + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign atTerminal = (countQ == terminal);

endmodule

// File: rtl/bubblesort_sequencer.sv
// Drives an external compare/exchange array: shifts keys in, runs the sort
// passes, then shifts the ordered keys out with a valid/ready handshake.
module bubblesort_sequencer
  import bubblesort_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PASSES = DEPTH
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic [WIDTH-1:0] ScanOut,
  input  logic [WIDTH-1:0] ScanIn,
  output logic             ScanEnable,
  output logic             Enable,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic             OutLast,
  output logic             Busy
);

  localparam int unsigned CntW = cntWidth(DEPTH, PASSES);
  localparam logic [CntW-1:0] LastKey  = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] LastPass = CntW'(PASSES - 1);

  sortState_e stateQ, stateD;
  logic cntClear, cntIncr, atTerminal;
  logic [CntW-1:0] terminal;

  bubblesort_beat_counter #(
    .CNT_W(CntW)
  ) u_beat_counter (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .clear     (cntClear),
    .incr      (cntIncr),
    .terminal  (terminal),
    .atTerminal(atTerminal)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      stateQ <= StLoad;
    end else begin
      stateQ <= stateD;
    end
  end

  // All handshake outputs are decoded combinationally so a key enters the
  // chain on the very edge it is accepted.
  always_comb begin
    stateD     = stateQ;
    cntClear   = 1'b0;
    cntIncr    = 1'b0;
    terminal   = LastKey;
    InReady    = 1'b0;
    ScanEnable = 1'b0;
    ScanOut    = '0;
    Enable     = 1'b0;
    OutValid   = 1'b0;
    case (stateQ)
      StLoad: begin
        InReady    = 1'b1;
        ScanEnable = InValid;
        ScanOut    = InValid ? InData : '0;
        if (InValid) begin
          if (atTerminal) begin
            cntClear = 1'b1;
            stateD   = StSort;
          end else begin
            cntIncr = 1'b1;
          end
        end
      end
      StSort: begin
        terminal = LastPass;
        Enable   = 1'b1;
        if (atTerminal) begin
          cntClear = 1'b1;
          stateD   = StUnload;
        end else begin
          cntIncr = 1'b1;
        end
      end
      StUnload: begin
        OutValid   = 1'b1;
        ScanEnable = OutReady;
        if (OutReady) begin
          if (atTerminal) begin
            cntClear = 1'b1;
            stateD   = StLoad;
          end else begin
            cntIncr = 1'b1;
          end
        end
      end
      default: begin
        cntClear = 1'b1;
        stateD   = StLoad;
      end
    endcase
  end

  assign OutData = (stateQ == StUnload) ? ScanIn : '0;
  assign OutLast = (stateQ == StUnload) && atTerminal;
  assign Busy    = (stateQ != StLoad);

endmodule

// File: doc/bubblesort_sequencer.md
BUBBLESORT_SEQUENCER -- requirements
Module: bubblesort_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: key width in bits, equal to the sort array register width.
REQ-002 SHALL have parameter DEPTH, default 8: number of registers in the array scan chain (keys per frame); legal range >= 2.
REQ-003 SHALL have parameter PASSES, default DEPTH: number of Enable cycles per sort; legal range >= 1.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port ResetN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port InValid, input, 1 bit: upstream key valid.
REQ-007 SHALL have port InReady, output, 1 bit: key accepted this cycle when high together with InValid.
REQ-008 SHALL have port InData, input, WIDTH bits: upstream key.
REQ-009 SHALL have port ScanOut, output, WIDTH bits: value driven into the first register of the array scan chain.
REQ-010 SHALL have port ScanIn, input, WIDTH bits: value read from the last register of the array scan chain.
REQ-011 SHALL have port ScanEnable, output, 1 bit: shift the array scan chain by one position at this edge.
REQ-012 SHALL have port Enable, output, 1 bit: array compare/exchange step enable.
REQ-013 SHALL have port OutValid, output, 1 bit: result key valid.
REQ-014 SHALL have port OutReady, input, 1 bit: downstream accepts the result key.
REQ-015 SHALL have port OutData, output, WIDTH bits: result key.
REQ-016 SHALL have port OutLast, output, 1 bit: marks the final result key of a frame.
REQ-017 SHALL have port Busy, output, 1 bit: high in SORT and UNLOAD.

Function
REQ-018 SHALL implement FSM states LOAD, SORT, UNLOAD, plus a beat counter of width clog2(max(DEPTH,PASSES)+1).
REQ-019 LOAD: InReady=1, Enable=0, OutValid=0; ScanEnable=InValid, ScanOut=InData; each handshake increments the counter.
REQ-020 LOAD: the handshake that brings the count to DEPTH SHALL clear the counter and move to SORT on the same edge.
REQ-021 SORT: Enable=1, InReady=0, ScanEnable=0, OutValid=0; the counter increments every cycle; after exactly PASSES cycles in SORT, clear the counter and go to UNLOAD.
REQ-022 UNLOAD: OutValid=1, OutData=ScanIn, ScanOut=0, ScanEnable=OutReady, Enable=0, InReady=0.
REQ-023 UNLOAD: each OutValid&OutReady handshake increments the counter; OutLast=1 when count==DEPTH-1.
REQ-024 UNLOAD: the last handshake SHALL clear the counter and return to LOAD; the next key SHALL NOT be accepted before the following cycle.
REQ-025 OutData and OutValid SHALL hold stable while OutReady is low (no drop, no duplicate).
REQ-026 InValid low in LOAD and OutReady low in UNLOAD SHALL stall without state or counter change.
REQ-027 ScanEnable and Enable SHALL never be high in the same cycle.
REQ-028 ScanOut SHALL be 0 whenever ScanEnable is 0.
REQ-029 InReady, OutValid, ScanEnable and Enable SHALL be decoded from state and handshakes only, with no registered latency; each key enters the chain on its handshake edge.

Reset
REQ-030 ResetN low SHALL immediately force state LOAD and counter 0, giving InReady=1, Busy=0, Enable=0, OutValid=0, OutLast=0, and ScanEnable=InValid.
REQ-031 Reset mid-frame SHALL abandon the frame; array contents are not cleared by this block.
REQ-032 Reset deassertion SHALL be synchronous to Clk at the integrating level; the first accepted key is at the first edge after release.

Structure
REQ-033 The shared package bubblesort_pkg SHALL hold the state enum (LOAD/SORT/UNLOAD) and the counter-width function.
REQ-034 The beat counter (clear, increment, terminal compare) SHALL be one sub-module, bubblesort_beat_counter.

Verification
REQ-035 Load 5,3,7,1,8,2,6,4 (WIDTH=8, DEPTH=8) with InValid held high -> 8 consecutive ScanEnable pulses; 8 Enable cycles; OutData sequence equal to the array model's sorted order; OutLast only on beat 8.
REQ-036 Apply random OutReady backpressure (50%) during UNLOAD -> exactly 8 handshakes; OutData stable while stalled; ScanEnable pulses only on handshakes.
REQ-037 Insert InValid gaps during LOAD -> no ScanEnable in gap cycles; SORT starts the cycle after the 8th handshake.
REQ-038 Pulse ResetN low during SORT at count 3 -> Enable drops immediately; InReady=1; the next frame loads 8 fresh keys correctly.
REQ-039 Use PASSES=1 and input 2,1,... -> Enable high for exactly 1 cycle; Enable and ScanEnable never overlap in any cycle.
REQ-040 Send two back-to-back frames with OutReady=1 -> InReady=0 during the last UNLOAD cycle and InReady=1 the cycle after.
